// File: rtl/bcam_mbist_mask_sequencer_pkg.sv
// Shared types and the mask pattern generator for the BCAM MBIST mask sequencer.
// The pattern function works on a wide vector; callers slice off their own RF_DWIDTH.
package bcam_mbist_pkg;

  typedef enum logic [1:0] {
    WALK1   = 2'd0,
    WALK0   = 2'd1,
    CHECKER = 2'd2,
    ALLONES = 2'd3
  } mask_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } seq_state_e;

  localparam int unsigned MAX_DWIDTH = 1024;
  typedef logic [MAX_DWIDTH-1:0] wide_mask_t;

  // dwidth and group are elaboration constants at every call site, so the loop
  // and division fold away; only the pos comparison remains as logic.
  function automatic wide_mask_t mask_pattern(input mask_mode_e  mode,
                                              input int unsigned pos,
                                              input int unsigned dwidth,
                                              input int unsigned group);
    wide_mask_t  m;
    int unsigned g;
    m = '0;
    for (int unsigned i = 0; i < dwidth; i++) begin
      g = i / group;
      case (mode)
        WALK1:   m[i] = (g == pos);
        WALK0:   m[i] = (g != pos);
        CHECKER: m[i] = (((g + pos) & 32'd1) == 32'd0);
        default: m[i] = 1'b1;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/bcam_mbist_mask_sequencer_if.sv
// Controller-side bundle of the BCAM MBIST mask sequencer: mask controls,
// BIST/functional data in, array write/compare data and sequencer status out.
interface bcam_mbist_mask_sequencer_if #(
  parameter int unsigned RF_DWIDTH  = 72,
  parameter int unsigned WR_PORTS   = 1,
  parameter int unsigned CM_PORTS   = 2,
  parameter int unsigned MASK_GROUP = 1
);
  localparam int unsigned NPOS  = RF_DWIDTH / MASK_GROUP;
  localparam int unsigned POS_W = (NPOS > 1) ? $clog2(NPOS) : 1;

  logic                                bist_cm_mode;
  logic [1:0]                          bist_mask_mode;
  logic                                bist_mask_load;
  logic                                bist_rotate_mask;
  logic [CM_PORTS-1:0]                 bist_cd_mask_enable;
  logic                                bist_data_inv;
  logic [WR_PORTS-1:0][RF_DWIDTH-1:0]  bist_wr_data;
  logic [CM_PORTS-1:0][RF_DWIDTH-1:0]  bist_cm_data;
  logic [CM_PORTS-1:0][RF_DWIDTH-1:0]  cm_data_func;
  logic                                fscan_mode;
  logic [WR_PORTS-1:0][RF_DWIDTH-1:0]  bist_wr_data_out;
  logic [CM_PORTS-1:0][RF_DWIDTH-1:0]  bist_cm_data_out;
  logic [POS_W-1:0]                    mask_pos;
  logic                                mask_valid;
  logic                                mask_wrap;

  modport master (
    output bist_cm_mode, bist_mask_mode, bist_mask_load, bist_rotate_mask,
           bist_cd_mask_enable, bist_data_inv, bist_wr_data, bist_cm_data,
           cm_data_func, fscan_mode,
    input  bist_wr_data_out, bist_cm_data_out, mask_pos, mask_valid, mask_wrap
  );

  modport slave (
    input  bist_cm_mode, bist_mask_mode, bist_mask_load, bist_rotate_mask,
           bist_cd_mask_enable, bist_data_inv, bist_wr_data, bist_cm_data,
           cm_data_func, fscan_mode,
    output bist_wr_data_out, bist_cm_data_out, mask_pos, mask_valid, mask_wrap
  );

endinterface

// File: rtl/bcam_mbist_mask_sequencer_mask_gen.sv
// Compare-mask sequencer: IDLE/ACTIVE state, position counter, latched mode,
// mask register with optional scan-mode capture, and the registered wrap flag.
module bcam_mbist_mask_gen
  import bcam_mbist_pkg::*;
#(
  parameter int unsigned RF_DWIDTH         = 72,
  parameter int unsigned MASK_GROUP        = 1,
  parameter int unsigned CAM_MATCH_ATPG_EN = 0,
  parameter int unsigned NPOS              = RF_DWIDTH / MASK_GROUP,
  parameter int unsigned POS_W             = (NPOS > 1) ? $clog2(NPOS) : 1
) (
  input  logic                 bist_clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 rotate,
  input  logic [1:0]           mode_in,
  input  logic                 fscan_mode,
  input  logic [RF_DWIDTH-1:0] capture_data,
  output logic [RF_DWIDTH-1:0] mask,
  output logic [POS_W-1:0]     mask_pos,
  output logic                 mask_valid,
  output logic                 mask_wrap
);

  seq_state_e           state_q, state_d;
  mask_mode_e           mode_q,  mode_d;
  logic [POS_W-1:0]     pos_q,   pos_d;
  logic [RF_DWIDTH-1:0] mask_q,  mask_d;
  logic                 wrap_q,  wrap_d;
  wide_mask_t           pattern;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    pos_d   = pos_q;
    mask_d  = mask_q;
    wrap_d  = 1'b0;
    pattern = '0;

    if (load) begin
      state_d = ACTIVE;
      mode_d  = mask_mode_e'(mode_in);
      pos_d   = '0;
      pattern = mask_pattern(mode_d, 32'd0, RF_DWIDTH, MASK_GROUP);
      mask_d  = pattern[RF_DWIDTH-1:0];
    end else if (rotate && state_q == ACTIVE) begin
      if (pos_q == POS_W'(NPOS - 1)) begin
        pos_d  = '0;
        wrap_d = 1'b1;
      end else begin
        pos_d  = pos_q + 1'b1;
      end
      pattern = mask_pattern(mode_q, 32'(pos_d), RF_DWIDTH, MASK_GROUP);
      mask_d  = pattern[RF_DWIDTH-1:0];
    end else if (CAM_MATCH_ATPG_EN != 0 && fscan_mode) begin
      // Scan capture only touches the mask; position and state stay put.
      mask_d = capture_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the blocking temporaries live in always_comb.
  always_ff @(posedge bist_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= WALK1;
      pos_q   <= '0;
      // NOTE: the mask is a plain flop vector (not a memory), so it is reset along with the rest.
      mask_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      mask_q  <= mask_d;
      wrap_q  <= wrap_d;
    end
  end

  assign mask       = mask_q;
  assign mask_pos   = pos_q;
  assign mask_valid = (state_q == ACTIVE);
  assign mask_wrap  = wrap_q;

endmodule

// File: rtl/bcam_mbist_mask_sequencer.sv
// BCAM MBIST front end: inverts write data per write port, builds masked compare
// data per CAM port, and optionally registers both data outputs.
module bcam_mbist_mask_sequencer
  import bcam_mbist_pkg::*;
#(
  parameter int unsigned RF_DWIDTH         = 72,
  parameter int unsigned WR_PORTS          = 1,
  parameter int unsigned CM_PORTS          = 2,
  parameter int unsigned MASK_GROUP        = 1,
  parameter int unsigned CAM_MATCH_ATPG_EN = 0,
  parameter int unsigned OUT_STAGE         = 1
) (
  input logic                         bist_clk,
  input logic                         rst,
  bcam_mbist_mask_sequencer_if.slave  bus
);

  localparam int unsigned NPOS  = RF_DWIDTH / MASK_GROUP;
  localparam int unsigned POS_W = (NPOS > 1) ? $clog2(NPOS) : 1;

  logic [RF_DWIDTH-1:0]               mask;
  logic [RF_DWIDTH-1:0]               cmp;
  logic [WR_PORTS-1:0][RF_DWIDTH-1:0] wr_out_d;
  logic [CM_PORTS-1:0][RF_DWIDTH-1:0] cm_out_d;

  bcam_mbist_mask_gen #(
    .RF_DWIDTH         (RF_DWIDTH),
    .MASK_GROUP        (MASK_GROUP),
    .CAM_MATCH_ATPG_EN (CAM_MATCH_ATPG_EN),
    .NPOS              (NPOS),
    .POS_W             (POS_W)
  ) u_mask_gen (
    .bist_clk     (bist_clk),
    .rst          (rst),
    .load         (bus.bist_mask_load),
    .rotate       (bus.bist_rotate_mask),
    .mode_in      (bus.bist_mask_mode),
    .fscan_mode   (bus.fscan_mode),
    .capture_data (bus.cm_data_func[0]),
    .mask         (mask),
    .mask_pos     (bus.mask_pos),
    .mask_valid   (bus.mask_valid),
    .mask_wrap    (bus.mask_wrap)
  );

  always_comb begin
    wr_out_d = '0;
    cm_out_d = '0;
    cmp      = '0;
    for (int w = 0; w < int'(WR_PORTS); w++) begin
      wr_out_d[w] = bus.bist_wr_data[w] ^ {RF_DWIDTH{bus.bist_data_inv}};
    end
    // CAM ports beyond the write-port count reuse write ports round-robin.
    for (int p = 0; p < int'(CM_PORTS); p++) begin
      cmp         = (bus.bist_cd_mask_enable[p] ? mask : '0) ^ wr_out_d[p % int'(WR_PORTS)];
      cm_out_d[p] = bus.bist_cm_mode ? cmp : bus.bist_cm_data[p];
    end
  end

  if (OUT_STAGE != 0) begin : g_out_reg
    logic [WR_PORTS-1:0][RF_DWIDTH-1:0] wr_out_q;
    logic [CM_PORTS-1:0][RF_DWIDTH-1:0] cm_out_q;

    always_ff @(posedge bist_clk or posedge rst) begin
      if (rst) begin
        wr_out_q <= '0;
        cm_out_q <= '0;
      end else begin
        wr_out_q <= wr_out_d;
        cm_out_q <= cm_out_d;
      end
    end

    assign bus.bist_wr_data_out = wr_out_q;
    assign bus.bist_cm_data_out = cm_out_q;
  end else begin : g_out_comb
    assign bus.bist_wr_data_out = wr_out_d;
    assign bus.bist_cm_data_out = cm_out_d;
  end

endmodule

// File: tb/tb_bcam_mbist_mask_sequencer.sv
// Bench for bcam_mbist_mask_sequencer: two configurations driven in lockstep and
// compared every cycle against a pattern-arithmetic reference model.
module tb_bcam_mbist_mask_sequencer;

  logic bist_clk = 1'b0;
  logic rst;
  always #5 bist_clk = ~bist_clk;

  // A: 8b, 1 write port, group 1, scan capture on, registered outputs.
  // B: 8b, 2 write ports, group 2, scan capture off, combinational outputs.
  bcam_mbist_mask_sequencer_if #(.RF_DWIDTH(8), .WR_PORTS(1), .CM_PORTS(2), .MASK_GROUP(1)) if_a ();
  bcam_mbist_mask_sequencer_if #(.RF_DWIDTH(8), .WR_PORTS(2), .CM_PORTS(2), .MASK_GROUP(2)) if_b ();

  bcam_mbist_mask_sequencer #(
    .RF_DWIDTH(8), .WR_PORTS(1), .CM_PORTS(2), .MASK_GROUP(1),
    .CAM_MATCH_ATPG_EN(1), .OUT_STAGE(1)
  ) dut_a (.bist_clk(bist_clk), .rst(rst), .bus(if_a.slave));

  bcam_mbist_mask_sequencer #(
    .RF_DWIDTH(8), .WR_PORTS(2), .CM_PORTS(2), .MASK_GROUP(2),
    .CAM_MATCH_ATPG_EN(0), .OUT_STAGE(0)
  ) dut_b (.bist_clk(bist_clk), .rst(rst), .bus(if_b.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus shared by both DUTs.
  logic            s_load, s_rot, s_inv, s_cm_mode, s_fscan;
  logic [1:0]      s_mode, s_en;
  logic [1:0][7:0] s_wr, s_cmd, s_func;

  // Reference model, index 0 = A, 1 = B.
  int              cfg_g    [2] = '{1, 2};
  int              cfg_npos [2] = '{8, 4};
  int              cfg_atpg [2] = '{1, 0};
  int              cfg_ostg [2] = '{1, 0};
  int              cfg_wrp  [2] = '{1, 2};
  bit              m_act    [2];
  int              m_mode   [2];
  int              m_pos    [2];
  logic [7:0]      m_mask   [2];
  bit              m_wrap   [2];
  logic [1:0][7:0] m_wr_reg [2];
  logic [1:0][7:0] m_cm_reg [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int mode, input int k, input int g);
    int ones;
    int m;
    ones = (1 << g) - 1;
    m    = 0;
    case (mode)
      0: m = ones << (k * g);
      1: m = ~(ones << (k * g));
      2: for (int grp = 0; grp < 8 / g; grp++) if (((grp + k) % 2) == 0) m |= ones << (grp * g);
      default: m = 255;
    endcase
    return m[7:0];
  endfunction

  function automatic logic [7:0] comb_wr(input int w);
    return s_wr[w] ^ {8{s_inv}};
  endfunction

  function automatic logic [7:0] comb_cm(input int d, input int p, input logic [7:0] mask);
    if (!s_cm_mode) return s_cmd[p];
    return (s_en[p] ? mask : 8'h00) ^ comb_wr(p % cfg_wrp[d]);
  endfunction

  function automatic logic [7:0] exp_wr(input int d, input int w);
    return (cfg_ostg[d] != 0) ? m_wr_reg[d][w] : comb_wr(w);
  endfunction

  function automatic logic [7:0] exp_cm(input int d, input int p);
    return (cfg_ostg[d] != 0) ? m_cm_reg[d][p] : comb_cm(d, p, m_mask[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_mode[d] = 0; m_pos[d] = 0; m_mask[d] = 8'h00; m_wrap[d] = 0;
      m_wr_reg[d] = '0; m_cm_reg[d] = '0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < cfg_wrp[d]; w++) m_wr_reg[d][w] = comb_wr(w);
      for (int p = 0; p < 2; p++) m_cm_reg[d][p] = comb_cm(d, p, m_mask[d]);
      if (s_load) begin
        m_act[d] = 1; m_mode[d] = int'(s_mode); m_pos[d] = 0; m_wrap[d] = 0;
        m_mask[d] = pat(m_mode[d], 0, cfg_g[d]);
      end else if (s_rot && m_act[d]) begin
        m_wrap[d] = (m_pos[d] == cfg_npos[d] - 1);
        m_pos[d]  = m_wrap[d] ? 0 : m_pos[d] + 1;
        m_mask[d] = pat(m_mode[d], m_pos[d], cfg_g[d]);
      end else begin
        m_wrap[d] = 0;
        if (cfg_atpg[d] != 0 && s_fscan) m_mask[d] = s_func[0];
      end
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, "_a_pos"},   32'(if_a.mask_pos),            32'(m_pos[0]));
    check({ph, "_a_valid"}, 32'(if_a.mask_valid),          32'(m_act[0]));
    check({ph, "_a_wrap"},  32'(if_a.mask_wrap),           32'(m_wrap[0]));
    check({ph, "_a_wr0"},   32'(if_a.bist_wr_data_out[0]), 32'(exp_wr(0, 0)));
    check({ph, "_a_cm0"},   32'(if_a.bist_cm_data_out[0]), 32'(exp_cm(0, 0)));
    check({ph, "_a_cm1"},   32'(if_a.bist_cm_data_out[1]), 32'(exp_cm(0, 1)));
    check({ph, "_b_pos"},   32'(if_b.mask_pos),            32'(m_pos[1]));
    check({ph, "_b_valid"}, 32'(if_b.mask_valid),          32'(m_act[1]));
    check({ph, "_b_wrap"},  32'(if_b.mask_wrap),           32'(m_wrap[1]));
    check({ph, "_b_wr0"},   32'(if_b.bist_wr_data_out[0]), 32'(exp_wr(1, 0)));
    check({ph, "_b_wr1"},   32'(if_b.bist_wr_data_out[1]), 32'(exp_wr(1, 1)));
    check({ph, "_b_cm0"},   32'(if_b.bist_cm_data_out[0]), 32'(exp_cm(1, 0)));
    check({ph, "_b_cm1"},   32'(if_b.bist_cm_data_out[1]), 32'(exp_cm(1, 1)));
  endtask

  task automatic drive();
    if_a.bist_cm_mode        = s_cm_mode;   if_b.bist_cm_mode        = s_cm_mode;
    if_a.bist_mask_mode      = s_mode;      if_b.bist_mask_mode      = s_mode;
    if_a.bist_mask_load      = s_load;      if_b.bist_mask_load      = s_load;
    if_a.bist_rotate_mask    = s_rot;       if_b.bist_rotate_mask    = s_rot;
    if_a.bist_cd_mask_enable = s_en;        if_b.bist_cd_mask_enable = s_en;
    if_a.bist_data_inv       = s_inv;       if_b.bist_data_inv       = s_inv;
    if_a.fscan_mode          = s_fscan;     if_b.fscan_mode          = s_fscan;
    if_a.bist_wr_data[0]     = s_wr[0];     if_b.bist_wr_data        = s_wr;
    if_a.bist_cm_data        = s_cmd;       if_b.bist_cm_data        = s_cmd;
    if_a.cm_data_func        = s_func;      if_b.cm_data_func        = s_func;
  endtask

  task automatic step(input string ph);
    @(posedge bist_clk);
    model_edge();
    #1;
    check_all(ph);
    #1;
  endtask

  // Asserted mid-cycle and released on the falling edge, so no rising edge sees it.
  task automatic do_reset(input string ph);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ph);
    check({ph, "_a_cm0_zero"}, 32'(if_a.bist_cm_data_out[0]), 32'h0);
    check({ph, "_a_pos_zero"}, 32'(if_a.mask_pos), 32'h0);
    @(negedge bist_clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] w0_seq [4];
    w0_seq = '{8'hF3, 8'hCF, 8'h3F, 8'hFC};

    s_load = 0; s_rot = 0; s_inv = 0; s_cm_mode = 0; s_fscan = 0;
    s_mode = 0; s_en = 0; s_wr = '0; s_cmd = '0; s_func = '0;
    rst = 1'b1;
    drive();
    model_reset();
    #3;
    check_all("reset");
    @(negedge bist_clk);
    rst = 1'b0;

    // Rotate before any load is ignored.
    s_rot = 1; drive(); step("pre");
    check("pre_a_valid", 32'(if_a.mask_valid), 32'h0);

    // Walk-1, group 1: registered A output trails the mask by one cycle.
    s_rot = 0; s_load = 1; s_mode = 2'd0; s_en = 2'b11; s_cm_mode = 1; drive(); step("w1_load");
    s_load = 0; s_rot = 1; drive();
    repeat (3) step("w1_rot");
    check("w1_a_pos3",   32'(if_a.mask_pos), 32'd3);
    check("w1_a_cm_lag", 32'(if_a.bist_cm_data_out[0]), 32'h04);
    s_rot = 0; drive(); step("w1_hold");
    check("w1_a_cm", 32'(if_a.bist_cm_data_out[0]), 32'h08);

    // Walk-0, group 2 on B: FC F3 CF 3F FC, wrap only on the last rotate.
    s_load = 1; s_mode = 2'd1; drive(); step("w0_load");
    check("w0_b_cm0_p0", 32'(if_b.bist_cm_data_out[0]), 32'hFC);
    s_load = 0; s_rot = 1; drive();
    for (int i = 0; i < 4; i++) begin
      step("w0_rot");
      check($sformatf("w0_b_cm0_r%0d", i), 32'(if_b.bist_cm_data_out[0]), 32'(w0_seq[i]));
      check($sformatf("w0_b_wrap_r%0d", i), 32'(if_b.mask_wrap), 32'(i == 3));
    end

    // Load beats rotate at pos 2.
    repeat (2) step("lr_pre");
    check("lr_b_pos2", 32'(if_b.mask_pos), 32'd2);
    s_load = 1; s_mode = 2'd2; drive(); step("lr");
    check("lr_b_pos",  32'(if_b.mask_pos), 32'd0);
    check("lr_b_wrap", 32'(if_b.mask_wrap), 32'd0);
    check("lr_b_cm0",  32'(if_b.bist_cm_data_out[0]), 32'h33);

    // Per-port enables with inverted write data, then pass-through.
    s_load = 0; s_rot = 0; s_en = 2'b10; s_wr = {8'hA5, 8'hA5}; s_inv = 1; drive(); step("en");
    check("en_b_cm0", 32'(if_b.bist_cm_data_out[0]), 32'h5A);
    check("en_b_cm1", 32'(if_b.bist_cm_data_out[1]), 32'h69);
    s_cm_mode = 0; s_cmd = {8'h96, 8'h3E}; drive(); step("pass");
    check("pass_b_cm0", 32'(if_b.bist_cm_data_out[0]), 32'h3E);
    check("pass_b_cm1", 32'(if_b.bist_cm_data_out[1]), 32'h96);

    // Scan capture: A takes cm_data_func[0], B holds its mask.
    s_cm_mode = 1; s_en = 2'b01; s_wr = '0; s_inv = 0; s_fscan = 1; s_func = {8'h00, 8'h3C};
    drive(); step("atpg_cap");
    s_fscan = 0; drive(); step("atpg_show");
    check("atpg_a_cm0", 32'(if_a.bist_cm_data_out[0]), 32'h3C);
    check("atpg_a_pos", 32'(if_a.mask_pos), 32'd0);
    check("atpg_b_cm0", 32'(if_b.bist_cm_data_out[0]), 32'h33);

    // Reset mid-walk at pos 5, then a rotate in IDLE does nothing.
    s_load = 1; s_mode = 2'd0; drive(); step("mid_load");
    s_load = 0; s_rot = 1; drive();
    repeat (5) step("mid_rot");
    check("mid_a_pos5", 32'(if_a.mask_pos), 32'd5);
    do_reset("mid_rst");
    step("post_rst_rot");
    check("post_a_valid", 32'(if_a.mask_valid), 32'h0);
    check("post_a_pos",   32'(if_a.mask_pos), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      s_load    = ($urandom % 8) == 0;
      s_rot     = ($urandom % 4) != 0;
      s_mode    = 2'($urandom);
      s_en      = 2'($urandom);
      s_inv     = 1'($urandom);
      s_cm_mode = ($urandom % 4) != 0;
      s_fscan   = ($urandom % 6) == 0;
      s_wr      = 16'($urandom);
      s_cmd     = 16'($urandom);
      s_func    = 16'($urandom);
      drive();
      if (($urandom % 200) == 0) do_reset("rnd_rst");
      else step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
